// File: rtl/s4ga_cfg_streamer.sv
// s4ga_cfg_streamer: buffers host config words in a 2-entry FIFO and streams
// them MSB-nibble-first onto the s4ga serial config port, tracking the
// position within a FRAME_WORDS-word frame.
// Ports:
//   clk, rst      - clock, synchronous active-low reset
//   en            - streaming enable
//   in_data/in_valid/in_ready - host word input (valid/ready handshake)
//   si/si_valid   - config nibble and its qualifier
//   frame_start   - si carries nibble 0 of word 0 of a frame
//   underrun      - sticky mid-frame starvation flag
//   busy          - streamer is not idle
module s4ga_cfg_streamer #(
  parameter int unsigned SI_W        = 4,
  parameter int unsigned WORD_W      = 16,
  parameter int unsigned FRAME_WORDS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [SI_W-1:0]   si,
  output logic              si_valid,
  output logic              frame_start,
  output logic              underrun,
  output logic              busy
);

  localparam int unsigned NPW   = WORD_W / SI_W;
  localparam int unsigned IDX_W = (NPW > 1) ? $clog2(NPW) : 1;
  localparam int unsigned WC_W  = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;

  state_t             state, state_n;
  logic [WORD_W-1:0]  mem [2];
  logic               rd_ptr, wr_ptr;
  logic [1:0]         count;
  logic [WORD_W-1:0]  shifter, shifter_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic [WC_W-1:0]    wcnt, wcnt_n;
  logic               underrun_q, set_underrun;
  logic               push, pop, empty, last_nib, wcnt_wrap;
  logic [WC_W-1:0]    wcnt_inc;

  // FIFO handshake: ready depends only on the registered occupancy
  assign in_ready  = (count < 2'd2);
  assign push      = in_valid & in_ready;
  assign empty     = (count == 2'd0);
  assign last_nib  = (idx == IDX_W'(NPW - 1));
  assign wcnt_wrap = (wcnt == WC_W'(FRAME_WORDS - 1));
  assign wcnt_inc  = wcnt_wrap ? '0 : WC_W'(wcnt + WC_W'(1));

  // 2-entry FIFO storage and pointers
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= 2'(count + 2'(push) - 2'(pop));
    end
  end

  // Streamer state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      shifter    <= '0;
      idx        <= '0;
      wcnt       <= '0;
      underrun_q <= 1'b0;
    end else begin
      state      <= state_n;
      shifter    <= shifter_n;
      idx        <= idx_n;
      wcnt       <= wcnt_n;
      underrun_q <= underrun_q | set_underrun;
    end
  end

  // Next-state / datapath control
  always_comb begin
    state_n      = state;
    shifter_n    = shifter;
    idx_n        = idx;
    wcnt_n       = wcnt;
    pop          = 1'b0;
    set_underrun = 1'b0;
    unique case (state)
      IDLE: begin
        if (en && !empty) begin
          pop       = 1'b1;
          shifter_n = mem[rd_ptr];
          idx_n     = '0;
          state_n   = RUN;
        end
      end
      RUN: begin
        shifter_n = shifter << SI_W;
        idx_n     = IDX_W'(idx + IDX_W'(1));
        if (last_nib) begin
          idx_n  = '0;
          wcnt_n = wcnt_inc;
          if (en && !empty) begin
            // seamless handoff to the next buffered word
            pop       = 1'b1;
            shifter_n = mem[rd_ptr];
          end else if (!en) begin
            state_n = IDLE;
          end else if (wcnt_wrap) begin
            // frame ended cleanly on a word boundary
            state_n = IDLE;
          end else begin
            state_n      = STALL;
            set_underrun = 1'b1;
          end
        end
      end
      STALL: begin
        if (!en) begin
          state_n = IDLE;
        end else if (!empty) begin
          pop       = 1'b1;
          shifter_n = mem[rd_ptr];
          idx_n     = '0;
          state_n   = RUN;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign si_valid    = (state == RUN);
  assign si          = si_valid ? shifter[WORD_W-1 -: SI_W] : '0;
  assign frame_start = si_valid && (wcnt == '0) && (idx == '0);
  assign underrun    = underrun_q;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_s4ga_cfg_streamer.sv
// Testbench for s4ga_cfg_streamer: directed word sequences, expected nibbles
// queued at issue time and checked by an independent monitor.
module tb_s4ga_cfg_streamer;

  localparam int unsigned SI_W   = 4;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned NPW    = 4;
  localparam int unsigned FW     = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              en = 1'b0;
  logic [WORD_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [SI_W-1:0]   si;
  logic              si_valid, frame_start, underrun, busy;

  s4ga_cfg_streamer #(.SI_W(SI_W), .WORD_W(WORD_W), .FRAME_WORDS(FW)) dut (
    .clk(clk), .rst(rst), .en(en), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .si(si), .si_valid(si_valid),
    .frame_start(frame_start), .underrun(underrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [3:0] nib;
    logic       fs;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   model_w = 0;
  int   acc_cyc = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Scoreboard monitor: every valid nibble must match the queue head
  always @(negedge clk) begin : mon
    exp_t e;
    if (si_valid === 1'b1) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_nibble: got si=%0h with nothing expected (t=%0t)", si, $time);
      end else begin
        e = q.pop_front();
        chk("si_nibble", 32'(si), 32'(e.nib));
        chk("frame_start", 32'(frame_start), 32'(e.fs));
      end
    end
  end

  // Streaming statistics for the back-to-back frame
  logic clr_stats = 1'b0;
  int   n_valid = 0, n_fs = 0, n_rise = 0, saw_full = 0;
  logic prev_v = 1'b0;
  always @(negedge clk) begin
    if (clr_stats) begin
      n_valid  = 0;
      n_fs     = 0;
      n_rise   = 0;
      saw_full = 0;
      prev_v   = 1'b0;
    end else begin
      if (si_valid) n_valid++;
      if (frame_start) n_fs++;
      if (si_valid && !prev_v) n_rise++;
      if (!in_ready) saw_full++;
      prev_v = si_valid;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [15:0] w);
    exp_t e;
    logic rdy;
    int   k;
    for (int i = 0; i < NPW; i++) begin
      e.nib = w[15-4*i -: 4];
      e.fs  = (model_w == 0) && (i == 0);
      q.push_back(e);
    end
    model_w  = (model_w + 1) % FW;
    in_data  = w;
    in_valid = 1'b1;
    rdy = 1'b0;
    k = 0;
    while (!rdy && k < 100) begin
      @(negedge clk);
      rdy     = in_ready;
      acc_cyc = cyc;
      @(posedge clk);
      #1;
      k++;
    end
    if (!rdy) chk("push_timeout", 32'(rdy), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (si_valid !== 1'b1 && k < 60);
    if (si_valid !== 1'b1) chk("wait_valid_timeout", 32'(si_valid), 32'd1);
  endtask

  task automatic wait_nib(input logic [3:0] n);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(si_valid === 1'b1 && si === n) && k < 60);
    if (!(si_valid === 1'b1 && si === n)) chk("wait_nib_timeout", 32'(si), 32'(n));
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 400) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk("drain_queue_empty", 32'(q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    en       = 1'b0;
    in_valid = 1'b0;
    tick(1);
    q.delete();
    model_w = 0;
    chk("rst_si_valid", 32'(si_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_underrun", 32'(underrun), 32'd0);
    rst = 1'b1;
    tick(1);
  endtask

  initial begin
    int k;
    // Power-on reset values
    tick(2);
    chk("init_si", 32'(si), 32'd0);
    chk("init_si_valid", 32'(si_valid), 32'd0);
    chk("init_frame_start", 32'(frame_start), 32'd0);
    chk("init_busy", 32'(busy), 32'd0);
    chk("init_in_ready", 32'(in_ready), 32'd1);
    chk("init_underrun", 32'(underrun), 32'd0);
    rst = 1'b1;
    tick(1);

    // Single word, two-cycle latency, en dropped mid-word -> clean idle
    en = 1'b1;
    push_word(16'hA5C3);
    wait_valid();
    chk("latency_t_plus_2", 32'(cyc - acc_cyc), 32'd2);
    en = 1'b0;
    tick(8);
    chk("single_busy", 32'(busy), 32'd0);
    chk("single_underrun", 32'(underrun), 32'd0);
    drain();

    // Full frame back-to-back, then a fresh frame
    do_reset();
    clr_stats = 1'b1;
    tick(1);
    clr_stats = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 16; i++) push_word(16'(i));
    drain();
    tick(4);
    chk("frame_valid_cycles", 32'(n_valid), 32'd64);
    chk("frame_start_count", 32'(n_fs), 32'd1);
    chk("frame_no_bubble", 32'(n_rise), 32'd1);
    chk("frame_in_ready_dropped", 32'(saw_full != 0), 32'd1);
    chk("frame_end_busy", 32'(busy), 32'd0);
    chk("frame_end_underrun", 32'(underrun), 32'd0);
    push_word(16'h0ABC);
    wait_valid();
    en = 1'b0;
    drain();
    tick(6);
    chk("frame2_busy", 32'(busy), 32'd0);

    // Starvation mid-frame
    do_reset();
    en = 1'b1;
    push_word(16'h1111);
    push_word(16'h2222);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(busy === 1'b1 && si_valid === 1'b0) && k < 60);
    for (int i = 0; i < 5; i++) begin
      if (i != 0) @(negedge clk);
      chk("stall_si", 32'(si), 32'd0);
      chk("stall_si_valid", 32'(si_valid), 32'd0);
      chk("stall_busy", 32'(busy), 32'd1);
      chk("stall_underrun", 32'(underrun), 32'd1);
    end
    push_word(16'h3333);
    wait_valid();
    en = 1'b0;
    drain();
    tick(6);
    chk("stall_end_busy", 32'(busy), 32'd0);
    chk("underrun_sticky", 32'(underrun), 32'd1);

    // en dropped at nibble 1: word completes, buffered words kept
    do_reset();
    en = 1'b1;
    push_word(16'hBEEF);
    push_word(16'h1234);
    push_word(16'h5678);
    wait_nib(4'hE);
    en = 1'b0;
    tick(8);
    chk("endrop_busy", 32'(busy), 32'd0);
    chk("endrop_fifo_retained", 32'(in_ready), 32'd0);
    chk("endrop_pending", 32'(q.size()), 32'd8);
    en = 1'b1;
    drain();
    tick(3);
    en = 1'b0;
    tick(4);
    chk("endrop_end_busy", 32'(busy), 32'd0);

    // Reset in the middle of a word with the FIFO full
    do_reset();
    en = 1'b1;
    push_word(16'h1357);
    push_word(16'h2468);
    push_word(16'h9ACE);
    wait_nib(4'h5);
    chk("midrst_fifo_full", 32'(in_ready), 32'd0);
    rst = 1'b0;
    tick(1);
    q.delete();
    model_w = 0;
    chk("midrst_si_valid", 32'(si_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    push_word(16'hF00D);
    wait_valid();
    chk("midrst_fresh_frame_start", 32'(frame_start), 32'd1);
    en = 1'b0;
    drain();
    tick(6);
    chk("final_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
